// File: rtl/sal_cmd_sched.sv
// rtl/sal_cmd_sched.sv - channel DRAM command scheduler, class priority + per-class round-robin
// Optional anti-starvation promotion enabled by defining SAL_CMD_SCHED_STARVE_EN.
`ifndef DRAM_RA_WIDTH
`define DRAM_RA_WIDTH 16
`endif
`ifndef DRAM_CA_WIDTH
`define DRAM_CA_WIDTH 10
`endif

module sal_cmd_sched #(
    parameter int NUM_BANKS    = 4,
    parameter int BA_WIDTH     = $clog2(NUM_BANKS),
    parameter int RA_WIDTH     = `DRAM_RA_WIDTH,
    parameter int CA_WIDTH     = `DRAM_CA_WIDTH,
    parameter int ID_WIDTH     = 4,
    parameter int LEN_WIDTH    = 4,
    parameter int STARVE_LIMIT = 15
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           stall_i,
    input  logic [NUM_BANKS-1:0]           act_req_i,
    input  logic [NUM_BANKS-1:0]           rd_req_i,
    input  logic [NUM_BANKS-1:0]           wr_req_i,
    input  logic [NUM_BANKS-1:0]           pre_req_i,
    input  logic [NUM_BANKS-1:0]           ref_req_i,
    input  logic [NUM_BANKS*RA_WIDTH-1:0]  ra_i,
    input  logic [NUM_BANKS*CA_WIDTH-1:0]  ca_i,
    input  logic [NUM_BANKS*ID_WIDTH-1:0]  id_i,
    input  logic [NUM_BANKS*LEN_WIDTH-1:0] len_i,
    output logic [NUM_BANKS-1:0]           act_gnt_o,
    output logic [NUM_BANKS-1:0]           rd_gnt_o,
    output logic [NUM_BANKS-1:0]           wr_gnt_o,
    output logic [NUM_BANKS-1:0]           pre_gnt_o,
    output logic [NUM_BANKS-1:0]           ref_gnt_o,
    output logic                           cmd_valid_o,
    output logic [2:0]                     cmd_o,
    output logic [BA_WIDTH-1:0]            cmd_ba_o,
    output logic [RA_WIDTH-1:0]            cmd_ra_o,
    output logic [CA_WIDTH-1:0]            cmd_ca_o,
    output logic [ID_WIDTH-1:0]            cmd_id_o,
    output logic [LEN_WIDTH-1:0]           cmd_len_o
);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;
    localparam logic [2:0] CMD_REF = 3'd5;

    localparam logic [1:0] CLS_REF = 2'd0;
    localparam logic [1:0] CLS_CAS = 2'd1;
    localparam logic [1:0] CLS_ACT = 2'd2;
    localparam logic [1:0] CLS_PRE = 2'd3;

    logic [BA_WIDTH-1:0]  ptr [4];
    logic [NUM_BANKS-1:0] cas_req;
    logic [NUM_BANKS-1:0] eff_ref;
    logic [NUM_BANKS-1:0] eff_cas;
    logic [NUM_BANKS-1:0] eff_act;
    logic [NUM_BANKS-1:0] eff_pre;
    logic [NUM_BANKS-1:0] any_req;
    logic [NUM_BANKS-1:0] cand;
    logic [NUM_BANKS-1:0] onehot;
    logic [1:0]           win_cls;
    logic [BA_WIDTH-1:0]  win;
    logic [BA_WIDTH-1:0]  idx;
    logic                 found;
    logic                 gnt;
    logic [2:0]           gnt_cmd;

`ifdef SAL_CMD_SCHED_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0]     wait_cnt [NUM_BANKS];
    logic [NUM_BANKS-1:0] starved;
    logic                 st_found;
    logic [BA_WIDTH-1:0]  st_bank;
`endif

    always_comb begin
        cas_req = rd_req_i | wr_req_i;
        eff_ref = ref_req_i;
        eff_cas = cas_req & ~ref_req_i;
        eff_act = act_req_i & ~ref_req_i & ~cas_req;
        eff_pre = pre_req_i & ~ref_req_i & ~cas_req & ~act_req_i;
        any_req = ref_req_i | cas_req | act_req_i | pre_req_i;

        win_cls = CLS_PRE;
        cand    = eff_pre;
        if (|eff_act) begin win_cls = CLS_ACT; cand = eff_act; end
        if (|eff_cas) begin win_cls = CLS_CAS; cand = eff_cas; end
        if (|eff_ref) begin win_cls = CLS_REF; cand = eff_ref; end

        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            idx = ptr[win_cls] + BA_WIDTH'(i);
            if (!found && cand[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end

`ifdef SAL_CMD_SCHED_STARVE_EN
        // A starved bank bypasses class priority but keeps its own class.
        st_found = 1'b0;
        st_bank  = '0;
        for (int b = 0; b < NUM_BANKS; b++)
            starved[b] = any_req[b] && (wait_cnt[b] >= CNT_W'(STARVE_LIMIT));
        for (int b = NUM_BANKS - 1; b >= 0; b--) begin
            if (starved[b]) begin
                st_found = 1'b1;
                st_bank  = BA_WIDTH'(b);
            end
        end
        if (st_found) begin
            found = 1'b1;
            win   = st_bank;
            if (eff_ref[st_bank])      win_cls = CLS_REF;
            else if (eff_cas[st_bank]) win_cls = CLS_CAS;
            else if (eff_act[st_bank]) win_cls = CLS_ACT;
            else                       win_cls = CLS_PRE;
        end
`endif

        gnt    = found & ~stall_i & rst_n;
        onehot = gnt ? (NUM_BANKS'(1) << win) : '0;

        case (win_cls)
            CLS_REF: gnt_cmd = CMD_REF;
            CLS_CAS: gnt_cmd = rd_req_i[win] ? CMD_RD : CMD_WR;
            CLS_ACT: gnt_cmd = CMD_ACT;
            default: gnt_cmd = CMD_PRE;
        endcase

        ref_gnt_o = (win_cls == CLS_REF) ? onehot : '0;
        rd_gnt_o  = (gnt_cmd == CMD_RD)  ? onehot : '0;
        wr_gnt_o  = (gnt_cmd == CMD_WR)  ? onehot : '0;
        act_gnt_o = (win_cls == CLS_ACT) ? onehot : '0;
        pre_gnt_o = (win_cls == CLS_PRE) ? onehot : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < 4; c++)
                ptr[c] <= '0;
        end else if (gnt) begin
            ptr[win_cls] <= win + BA_WIDTH'(1);
        end
    end

`ifdef SAL_CMD_SCHED_STARVE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < NUM_BANKS; b++)
                wait_cnt[b] <= '0;
        end else if (!stall_i) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (!any_req[b] || (gnt && win == BA_WIDTH'(b)))
                    wait_cnt[b] <= '0;
                else if (wait_cnt[b] != {CNT_W{1'b1}})
                    wait_cnt[b] <= wait_cnt[b] + CNT_W'(1);
            end
        end
    end
`endif

    // Payload fields only move on a real grant so the bus stays quiet on NOPs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_valid_o <= 1'b0;
            cmd_o       <= CMD_NOP;
            cmd_ba_o    <= '0;
            cmd_ra_o    <= '0;
            cmd_ca_o    <= '0;
            cmd_id_o    <= '0;
            cmd_len_o   <= '0;
        end else if (gnt) begin
            cmd_valid_o <= 1'b1;
            cmd_o       <= gnt_cmd;
            cmd_ba_o    <= win;
            cmd_ra_o    <= ra_i[win*RA_WIDTH +: RA_WIDTH];
            cmd_ca_o    <= ca_i[win*CA_WIDTH +: CA_WIDTH];
            cmd_id_o    <= id_i[win*ID_WIDTH +: ID_WIDTH];
            cmd_len_o   <= len_i[win*LEN_WIDTH +: LEN_WIDTH];
        end else begin
            cmd_valid_o <= 1'b0;
            cmd_o       <= CMD_NOP;
        end
    end

endmodule

// File: tb/tb_sal_cmd_sched.sv
// tb/tb_sal_cmd_sched.sv - table-driven and scoreboard bench for sal_cmd_sched
module tb_sal_cmd_sched;

    localparam int NB = 4;
    localparam int RW = 16;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          stall = 1'b0;
    logic [NB-1:0] act_req = '0, rd_req = '0, wr_req = '0, pre_req = '0, ref_req = '0;
    logic [NB*RW-1:0] ra;
    logic [NB*CW-1:0] ca;
    logic [NB*4-1:0]  id;
    logic [NB*4-1:0]  len;
    logic [NB-1:0] act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic          cmd_valid;
    logic [2:0]    cmd;
    logic [1:0]    cmd_ba;
    logic [RW-1:0] cmd_ra;
    logic [CW-1:0] cmd_ca;
    logic [3:0]    cmd_id;
    logic [3:0]    cmd_len;

    sal_cmd_sched #(.NUM_BANKS(NB), .RA_WIDTH(RW), .CA_WIDTH(CW), .ID_WIDTH(4),
                    .LEN_WIDTH(4), .STARVE_LIMIT(15)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall),
        .act_req_i(act_req), .rd_req_i(rd_req), .wr_req_i(wr_req),
        .pre_req_i(pre_req), .ref_req_i(ref_req),
        .ra_i(ra), .ca_i(ca), .id_i(id), .len_i(len),
        .act_gnt_o(act_gnt), .rd_gnt_o(rd_gnt), .wr_gnt_o(wr_gnt),
        .pre_gnt_o(pre_gnt), .ref_gnt_o(ref_gnt),
        .cmd_valid_o(cmd_valid), .cmd_o(cmd), .cmd_ba_o(cmd_ba),
        .cmd_ra_o(cmd_ra), .cmd_ca_o(cmd_ca), .cmd_id_o(cmd_id), .cmd_len_o(cmd_len)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       stall;
        logic [3:0] act, rd, wr, pre, rf;
        logic [19:0] eg;   // {ref,pre,wr,rd,act} grants
        logic [2:0] ec;
        logic [1:0] eb;
    } vec_t;

    typedef struct {
        logic          valid;
        logic [2:0]    cmd;
        logic [1:0]    ba;
        logic [RW-1:0] ra;
        logic [CW-1:0] ca;
        logic [3:0]    id;
        logic [3:0]    len;
    } exp_t;

    vec_t tbl [18];
    exp_t exp_q [$];
    exp_t last;
    int   n_pass = 0;
    int   n_tot  = 0;

    function automatic logic [RW-1:0] bank_ra(input int b);  return RW'(16'h0100 + b); endfunction
    function automatic logic [CW-1:0] bank_ca(input int b);  return CW'(10'h020 + b); endfunction
    function automatic logic [3:0]    bank_id(input int b);  return 4'(b + 5); endfunction
    function automatic logic [3:0]    bank_len(input int b); return 4'(b + 1); endfunction

    function automatic vec_t mk(input logic s, input logic [3:0] a, r, w, p, f,
                                input logic [19:0] eg, input logic [2:0] ec, input logic [1:0] eb);
        vec_t v;
        v.stall = s; v.act = a; v.rd = r; v.wr = w; v.pre = p; v.rf = f;
        v.eg = eg; v.ec = ec; v.eb = eb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        n_tot++;
        if (act_v !== exp_v)
            $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
        else
            n_pass++;
    endtask

    task automatic check_cmd(input string tag);
        exp_t e;
        e = exp_q.pop_front();
        chk({tag, " cmd_valid"}, 32'(cmd_valid), 32'(e.valid));
        chk({tag, " cmd"},       32'(cmd),       32'(e.cmd));
        chk({tag, " cmd_ba"},    32'(cmd_ba),    32'(e.ba));
        chk({tag, " cmd_ra"},    32'(cmd_ra),    32'(e.ra));
        chk({tag, " cmd_ca"},    32'(cmd_ca),    32'(e.ca));
        chk({tag, " cmd_id"},    32'(cmd_id),    32'(e.id));
        chk({tag, " cmd_len"},   32'(cmd_len),   32'(e.len));
    endtask

    task automatic push_exp(input logic v, input logic [2:0] c, input logic [1:0] b);
        exp_t e;
        if (v) begin
            last.ba  = b;
            last.ra  = bank_ra(int'(b));
            last.ca  = bank_ca(int'(b));
            last.id  = bank_id(int'(b));
            last.len = bank_len(int'(b));
        end
        e = last;
        e.valid = v;
        e.cmd   = v ? c : 3'd0;
        exp_q.push_back(e);
    endtask

    function automatic logic [19:0] all_gnt();
        return {ref_gnt, pre_gnt, wr_gnt, rd_gnt, act_gnt};
    endfunction

    task automatic clear_reqs();
        act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0; stall = 1'b0;
    endtask

    initial begin
        for (int b = 0; b < NB; b++) begin
            ra[b*RW +: RW] = bank_ra(b);
            ca[b*CW +: CW] = bank_ca(b);
            id[b*4 +: 4]   = bank_id(b);
            len[b*4 +: 4]  = bank_len(b);
        end
        last = '{valid: 1'b0, cmd: 3'd0, ba: 2'd0, ra: '0, ca: '0, id: 4'd0, len: 4'd0};

        //             stall act     rd      wr      pre     ref     {ref,pre,wr,rd,act}            cmd ba
        tbl[0]  = mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 20'h00000, 3'd0, 2'd0);
        tbl[1]  = mk(0, 4'h8, 4'h4, 4'h0, 4'h0, 4'h2, 20'h20000, 3'd5, 2'd1);
        tbl[2]  = mk(0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 20'h00001, 3'd1, 2'd0);
        tbl[3]  = mk(0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 20'h00002, 3'd1, 2'd1);
        tbl[4]  = mk(0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 20'h00004, 3'd1, 2'd2);
        tbl[5]  = mk(0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h0, 20'h00008, 3'd1, 2'd3);
        tbl[6]  = mk(0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 20'h00010, 3'd2, 2'd0);
        tbl[7]  = mk(1, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 20'h00000, 3'd0, 2'd0);
        tbl[8]  = mk(1, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 20'h00000, 3'd0, 2'd0);
        tbl[9]  = mk(1, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 20'h00000, 3'd0, 2'd0);
        tbl[10] = mk(0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 20'h00400, 3'd3, 2'd2);
        tbl[11] = mk(0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 20'h00010, 3'd2, 2'd0);
        tbl[12] = mk(0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h0, 20'h00020, 3'd2, 2'd1);
        tbl[13] = mk(0, 4'h4, 4'h0, 4'h0, 4'hF, 4'h0, 20'h00004, 3'd1, 2'd2);
        tbl[14] = mk(0, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 20'h01000, 3'd4, 2'd0);
        tbl[15] = mk(0, 4'h0, 4'h0, 4'h1, 4'h8, 4'h8, 20'h80000, 3'd5, 2'd3);
        tbl[16] = mk(0, 4'h0, 4'h3, 4'h0, 4'h0, 4'h3, 20'h10000, 3'd5, 2'd0);
        tbl[17] = mk(0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 20'h00000, 3'd0, 2'd0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset cmd_valid", 32'(cmd_valid), 32'd0);
        chk("reset cmd", 32'(cmd), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (exp_q.size() > 0) check_cmd($sformatf("vec%0d", i - 1));
            stall = tbl[i].stall;
            act_req = tbl[i].act; rd_req = tbl[i].rd; wr_req = tbl[i].wr;
            pre_req = tbl[i].pre; ref_req = tbl[i].rf;
            #1;
            chk($sformatf("vec%0d grants", i), 32'(all_gnt()), 32'(tbl[i].eg));
            push_exp(!tbl[i].stall && tbl[i].eg != 20'h0, tbl[i].ec, tbl[i].eb);
        end
        @(negedge clk);
        check_cmd("vec17");
        clear_reqs();

        // Asynchronous reset mid-stream with ACT requests pending
        act_req = 4'hF;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async rst grants", 32'(all_gnt()), 32'd0);
        chk("async rst cmd_valid", 32'(cmd_valid), 32'd0);
        chk("async rst cmd", 32'(cmd), 32'd0);
        chk("async rst cmd_ba", 32'(cmd_ba), 32'd0);
        chk("async rst cmd_ra", 32'(cmd_ra), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post rst act_gnt", 32'(act_gnt), 32'h1);
        @(negedge clk);
        chk("post rst cmd_valid", 32'(cmd_valid), 32'd1);
        chk("post rst cmd", 32'(cmd), 32'd1);
        chk("post rst cmd_ba", 32'(cmd_ba), 32'd0);
        chk("post rst cmd_ra", 32'(cmd_ra), 32'(bank_ra(0)));
        clear_reqs();

`ifdef SAL_CMD_SCHED_STARVE_EN
        // Bank 3 PRE must win after waiting STARVE_LIMIT cycles behind CAS traffic
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rd_req = 4'h7;
        pre_req = 4'h8;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (c < 15) begin
                chk($sformatf("starve c%0d pre_gnt", c), 32'(pre_gnt), 32'h0);
            end else begin
                chk("starve pre_gnt", 32'(pre_gnt), 32'h8);
                chk("starve rd_gnt", 32'(rd_gnt), 32'h0);
            end
            @(negedge clk);
        end
        chk("starve cmd", 32'(cmd), 32'd4);
        chk("starve cmd_ba", 32'(cmd_ba), 32'd3);
        clear_reqs();
`endif

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
